// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder standing in for an M25P-style configuration flash.
// Oversamples SCK/CSB/MOSI in the CLK domain; array traffic goes out on a byte-wide memory port.
module spi_flash_responder #(
   parameter int          AW          = 16,
   parameter logic [23:0] JEDEC_ID    = 24'h202015,
   parameter int          PROG_CYCLES = 1000
) (
   input  logic          CLK,
   input  logic          RESETB,
   input  logic          SCK,
   input  logic          CSB,
   input  logic          MOSI,
   output logic          MISO,
   output logic          MISO_OE,
   output logic [AW-1:0] MEM_ADDR,
   output logic          MEM_RD,
   input  logic [7:0]    MEM_RDATA,
   output logic          MEM_WE,
   output logic [7:0]    MEM_WDATA
);
   // state     | meaning
   // ST_IDLE   | CSB high, waiting for select
   // ST_CMD    | shifting in the opcode byte
   // ST_ADDR   | shifting in the 24-bit address (READ / PP)
   // ST_DOUT   | driving READ / RDID / RDSR data on MISO
   // ST_DIN    | receiving page-program data bytes
   // ST_IGNORE | rest of the transaction is discarded
   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DOUT, ST_DIN, ST_IGNORE
   } state_t;

   typedef enum logic [1:0] {OP_READ, OP_PP, OP_RDID, OP_RDSR} op_t;

   localparam int CW = $clog2(PROG_CYCLES + 1);

   state_t        state, state_nxt;
   op_t           op, cmd_op;
   logic [2:0]    sck_q;
   logic [1:0]    csb_q;
   logic [1:0]    mosi_q;
   logic          csb_d;
   logic          sck_rise, sck_fall, csb_rise;
   logic [4:0]    bit_cnt;
   logic [6:0]    rx_sr;
   logic [7:0]    rx_byte;
   logic [7:0]    tx_sr;
   logic [AW-1:0] addr_reg, addr_in;
   logic          rd_pend;
   logic          pp_wrote;
   logic [1:0]    id_idx;
   logic [7:0]    id_byte;
   logic          wel, wip;
   logic [CW-1:0] wip_cnt;
   logic          byte_done, addr_done;
   logic [7:0]    status;

   // A CSB rise masks any SCK edge detected in the same cycle.
   assign csb_rise  = csb_q[1] & ~csb_d;
   assign sck_rise  = sck_q[1] & ~sck_q[2] & ~csb_rise;
   assign sck_fall  = ~sck_q[1] & sck_q[2] & ~csb_rise;
   assign rx_byte   = {rx_sr, mosi_q[1]};
   assign addr_in   = {addr_reg[AW-2:0], mosi_q[1]};
   assign byte_done = sck_rise && (bit_cnt[2:0] == 3'd7);
   assign addr_done = sck_rise && (bit_cnt == 5'd23);
   assign status    = {6'b0, wel, wip};

   always_comb begin
      id_byte = 8'h00;
      case (id_idx)
         2'd1:    id_byte = JEDEC_ID[15:8];
         2'd2:    id_byte = JEDEC_ID[7:0];
         default: id_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cmd_op    = OP_RDSR;
      case (rx_byte)
         8'h03:   cmd_op = OP_READ;
         8'h02:   cmd_op = OP_PP;
         8'h9F:   cmd_op = OP_RDID;
         default: cmd_op = OP_RDSR;
      endcase
      if (csb_rise) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (!csb_q[1]) state_nxt = ST_CMD;
            ST_CMD: begin
               if (byte_done) begin
                  case (rx_byte)
                     8'h03:        state_nxt = wip ? ST_IGNORE : ST_ADDR;
                     8'h02:        state_nxt = (wel && !wip) ? ST_ADDR : ST_IGNORE;
                     8'h9F, 8'h05: state_nxt = ST_DOUT;
                     default:      state_nxt = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: if (addr_done) state_nxt = (op == OP_READ) ? ST_DOUT : ST_DIN;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETB) begin
         state     <= ST_IDLE;
         op        <= OP_RDSR;
         sck_q     <= '0;
         csb_q     <= 2'b11;
         csb_d     <= 1'b1;
         mosi_q    <= '0;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         addr_reg  <= '0;
         rd_pend   <= 1'b0;
         pp_wrote  <= 1'b0;
         id_idx    <= '0;
         wel       <= 1'b0;
         wip       <= 1'b0;
         wip_cnt   <= '0;
         MISO      <= 1'b0;
         MISO_OE   <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_RD    <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_WDATA <= '0;
      end else begin
         sck_q   <= {sck_q[1:0], SCK};
         csb_q   <= {csb_q[0], CSB};
         mosi_q  <= {mosi_q[0], MOSI};
         csb_d   <= csb_q[1];
         state   <= state_nxt;
         MEM_RD  <= 1'b0;
         MEM_WE  <= 1'b0;
         rd_pend <= MEM_RD;

         // Program-busy timer: terminal count at 1 so WIP drops as the count hits 0.
         if (wip) begin
            wip_cnt <= wip_cnt - CW'(1);
            if (wip_cnt == CW'(1)) wip <= 1'b0;
         end

         if (csb_rise) begin
            bit_cnt  <= '0;
            MISO     <= 1'b0;
            MISO_OE  <= 1'b0;
            pp_wrote <= 1'b0;
            if (state == ST_DIN && pp_wrote) begin
               wip     <= 1'b1;
               wip_cnt <= CW'(PROG_CYCLES);
               wel     <= 1'b0;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  bit_cnt  <= '0;
                  rx_sr    <= '0;
                  pp_wrote <= 1'b0;
                  id_idx   <= '0;
                  MISO     <= 1'b0;
                  MISO_OE  <= 1'b0;
               end
               ST_CMD: begin
                  if (sck_rise) begin
                     rx_sr   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 5'd1;
                  end
                  if (byte_done) begin
                     bit_cnt <= '0;
                     op      <= cmd_op;
                     case (rx_byte)
                        8'h06: if (!wip) wel <= 1'b1;
                        8'h04: wel <= 1'b0;
                        8'h9F: begin
                           tx_sr  <= JEDEC_ID[23:16];
                           id_idx <= 2'd1;
                        end
                        8'h05:   tx_sr <= status;
                        default: ;
                     endcase
                  end
               end
               ST_ADDR: begin
                  if (sck_rise) begin
                     addr_reg <= addr_in;
                     bit_cnt  <= bit_cnt + 5'd1;
                  end
                  if (addr_done) begin
                     bit_cnt <= '0;
                     if (op == OP_READ) begin
                        MEM_RD   <= 1'b1;
                        MEM_ADDR <= addr_in;
                     end
                  end
               end
               ST_DOUT: begin
                  if (sck_fall) begin
                     MISO_OE <= 1'b1;
                     MISO    <= tx_sr[7];
                     tx_sr   <= {tx_sr[6:0], 1'b0};
                  end
                  if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
                  if (byte_done) begin
                     case (op)
                        OP_READ: begin
                           addr_reg <= addr_reg + AW'(1);
                           MEM_ADDR <= addr_reg + AW'(1);
                           MEM_RD   <= 1'b1;
                        end
                        OP_RDID: begin
                           tx_sr <= id_byte;
                           if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end
                        default: tx_sr <= status;
                     endcase
                  end
               end
               ST_DIN: begin
                  if (sck_rise) begin
                     rx_sr   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 5'd1;
                  end
                  // Page program wraps inside the 256-byte page.
                  if (byte_done) begin
                     MEM_WE         <= 1'b1;
                     MEM_ADDR       <= addr_reg;
                     MEM_WDATA      <= rx_byte;
                     addr_reg[7:0]  <= addr_reg[7:0] + 8'd1;
                     pp_wrote       <= 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // Read data arrives the cycle after MEM_RD; SCK fall is several cycles away.
         if (rd_pend) tx_sr <= MEM_RDATA;
      end
   end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: an SPI master drives commands while
// scoreboards hold the expected MISO bytes and memory writes.
module tb_spi_flash_responder;
   localparam int AW   = 16;
   localparam int HALF = 8;
   localparam int PROG = 1000;

   logic          CLK = 1'b0;
   logic          RESETB = 1'b0;
   logic          SCK = 1'b0;
   logic          CSB = 1'b1;
   logic          MOSI = 1'b0;
   logic          MISO, MISO_OE;
   logic [AW-1:0] MEM_ADDR;
   logic          MEM_RD, MEM_WE;
   logic [7:0]    MEM_RDATA = 8'h00;
   logic [7:0]    MEM_WDATA;

   logic [7:0]  mem [65536];
   logic [7:0]  exp_q [$];
   logic [23:0] exp_wr [$];
   int          n_checks = 0;
   int          n_err = 0;
   int          we_cnt = 0;

   spi_flash_responder #(.AW(AW), .JEDEC_ID(24'h202015), .PROG_CYCLES(PROG)) dut (
      .CLK(CLK), .RESETB(RESETB), .SCK(SCK), .CSB(CSB), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
      .MEM_RDATA(MEM_RDATA), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (MEM_RD) MEM_RDATA <= mem[MEM_ADDR];
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write scoreboard plus strobe exclusivity.
   always @(negedge CLK) begin
      if (RESETB && (MEM_RD || MEM_WE)) check("strobe_excl", {31'b0, MEM_RD & MEM_WE}, 32'd0);
      if (RESETB && MEM_WE) begin
         we_cnt++;
         n_checks++;
         assert (exp_wr.size() != 0) else begin
            n_err++;
            $error("FAIL we_unexpected: observed addr %h data %h expected no write", MEM_ADDR, MEM_WDATA);
         end
         if (exp_wr.size() != 0) check("mem_we", {8'h0, MEM_ADDR, MEM_WDATA}, {8'h0, exp_wr.pop_front()});
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
      for (int i = 7; i >= 0; i--) begin
         MOSI = tx[i];
         wait_clk(HALF);
         rx[i] = MISO;
         oe[i] = MISO_OE;
         SCK = 1'b1;
         wait_clk(HALF);
         SCK = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] tx);
      logic [7:0] rx, oe;
      xfer(tx, rx, oe);
   endtask

   task automatic send_cmd(input string tag, input logic [7:0] tx);
      logic [7:0] rx, oe;
      xfer(tx, rx, oe);
      check({tag, "_cmd_oe"}, {24'h0, oe}, 32'h0);
   endtask

   task automatic recv(input string tag);
      logic [7:0] rx, oe, e;
      xfer(8'h00, rx, oe);
      e = exp_q.pop_front();
      check(tag, {24'h0, rx}, {24'h0, e});
      check({tag, "_oe"}, {24'h0, oe}, 32'hFF);
   endtask

   task automatic cs_low();
      CSB = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_high();
      wait_clk(HALF);
      CSB = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic rdsr(input string tag, input logic [7:0] e);
      cs_low();
      send_cmd(tag, 8'h05);
      exp_q.push_back(e);
      recv(tag);
      cs_high();
   endtask

   task automatic cmd_only(input logic [7:0] c);
      cs_low();
      send(c);
      cs_high();
   endtask

   task automatic send_addr(input logic [23:0] a);
      send(a[23:16]);
      send(a[15:8]);
      send(a[7:0]);
   endtask

   initial begin
      int wc;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'hFFFF] = 8'hA5;
      mem[16'h0000] = 8'h3C;
      mem[16'h1300] = 8'h77;

      wait_clk(5);
      check("reset_outs", {4'h0, MISO, MISO_OE, MEM_RD, MEM_WE, MEM_ADDR, MEM_WDATA}, 32'h0);
      RESETB = 1'b1;
      wait_clk(5);

      // RDID
      cs_low();
      send_cmd("rdid", 8'h9F);
      exp_q.push_back(8'h20); exp_q.push_back(8'h20); exp_q.push_back(8'h15);
      exp_q.push_back(8'h00);
      recv("rdid_b0"); recv("rdid_b1"); recv("rdid_b2"); recv("rdid_b3");
      cs_high();
      check("rdid_oe_after", {30'h0, MISO_OE, MISO}, 32'h0);

      // READ across the top of the address space
      cs_low();
      send_cmd("read", 8'h03);
      send_addr(24'h00FFFF);
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
      recv("read_b0"); recv("read_b1");
      cs_high();

      // Program flow with in-page wrap
      rdsr("sr_init", 8'h00);
      cmd_only(8'h06);
      rdsr("sr_wel", 8'h02);
      cs_low();
      send_cmd("pp", 8'h02);
      send_addr(24'h0012FE);
      exp_wr.push_back({16'h12FE, 8'h11});
      exp_wr.push_back({16'h12FF, 8'h22});
      exp_wr.push_back({16'h1200, 8'h33});
      send(8'h11); send(8'h22); send(8'h33);
      cs_high();
      check("pp_we_count", we_cnt, 32'd3);
      rdsr("sr_busy", 8'h01);
      cmd_only(8'h06);
      rdsr("sr_wren_busy", 8'h01);
      wait_clk(PROG);
      rdsr("sr_done", 8'h00);

      // READ back across the page end: sequential read is not page-limited
      cs_low();
      send_cmd("readback", 8'h03);
      send_addr(24'h0012FF);
      exp_q.push_back(8'h22); exp_q.push_back(8'h77);
      recv("rb_b0"); recv("rb_b1");
      cs_high();

      // PP without WREN
      wc = we_cnt;
      cs_low();
      send(8'h02);
      send_addr(24'h000000);
      send(8'h55);
      cs_high();
      check("pp_nowel_we", we_cnt - wc, 32'd0);
      rdsr("sr_nowel", 8'h00);

      // Aborted PP: half a byte then deselect
      cmd_only(8'h06);
      wc = we_cnt;
      cs_low();
      send(8'h02);
      send_addr(24'h000000);
      for (int i = 0; i < 4; i++) begin
         MOSI = 1'b1;
         wait_clk(HALF);
         SCK = 1'b1;
         wait_clk(HALF);
         SCK = 1'b0;
      end
      cs_high();
      check("pp_abort_we", we_cnt - wc, 32'd0);
      rdsr("sr_abort", 8'h02);
      cmd_only(8'h04);
      rdsr("sr_wrdi", 8'h00);

      // Reset in the middle of a READ data byte
      cs_low();
      send(8'h03);
      send_addr(24'h00FFFF);
      exp_q.push_back(8'hA5);
      recv("rst_rd_b0");
      for (int i = 0; i < 4; i++) begin
         wait_clk(HALF);
         SCK = 1'b1;
         wait_clk(HALF);
         SCK = 1'b0;
      end
      wait_clk(HALF);
      check("pre_rst_oe", {31'h0, MISO_OE}, 32'h1);
      RESETB = 1'b0;
      @(posedge CLK);
      #1;
      check("rst_mid_outs", {4'h0, MISO, MISO_OE, MEM_RD, MEM_WE, MEM_ADDR, MEM_WDATA}, 32'h0);
      wait_clk(3);
      RESETB = 1'b1;
      wait_clk(2);
      cs_high();
      cs_low();
      send_cmd("rdid2", 8'h9F);
      exp_q.push_back(8'h20); exp_q.push_back(8'h20); exp_q.push_back(8'h15);
      recv("rdid2_b0"); recv("rdid2_b1"); recv("rdid2_b2");
      cs_high();
      rdsr("sr_after_rst", 8'h00);

      wait_clk(10);
      check("exp_q_empty", exp_q.size(), 32'd0);
      check("exp_wr_empty", exp_wr.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
